// File: rtl/cpu_seq_ctrl_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : cpu_seq_ctrl_if
// Description : Bundle between the CPU sequencer and its datapath/debug side.
//               slave  : the sequencer (consumes *_i, drives *_o)
//               master : the datapath / debug host driving the sequencer
//               Signals: run_i, step_i, bp_en_i, bp_addr_i[31:0], pc_i[31:0],
//               mem_op_i -> sequencer; ir_we_o, dm_en_o, rf_we_en_o, pc_we_o,
//               phase_o[2:0], busy_o, halted_o, instr_cnt_o[31:0] <- sequencer
// Revision    : 1.0 - initial release
// ============================================================================
interface cpu_seq_ctrl_if;
    logic        run_i;
    logic        step_i;
    logic        bp_en_i;
    logic [31:0] bp_addr_i;
    logic [31:0] pc_i;
    logic        mem_op_i;
    logic        ir_we_o;
    logic        dm_en_o;
    logic        rf_we_en_o;
    logic        pc_we_o;
    logic [2:0]  phase_o;
    logic        busy_o;
    logic        halted_o;
    logic [31:0] instr_cnt_o;

    modport slave (
        input  run_i, step_i, bp_en_i, bp_addr_i, pc_i, mem_op_i,
        output ir_we_o, dm_en_o, rf_we_en_o, pc_we_o, phase_o, busy_o,
               halted_o, instr_cnt_o
    );

    modport master (
        output run_i, step_i, bp_en_i, bp_addr_i, pc_i, mem_op_i,
        input  ir_we_o, dm_en_o, rf_we_en_o, pc_we_o, phase_o, busy_o,
               halted_o, instr_cnt_o
    );
endinterface
`default_nettype wire

// File: rtl/cpu_seq_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : cpu_seq_ctrl
// Description : Multi-cycle CPU sequencer. Walks FETCH/DECODE/EXEC/(MEM)/WB,
//               paced by a free-running divider in run mode or by step_i
//               rising edges in single-step mode, with a PC breakpoint.
// Ports       : clk  - clock, rising edge
//               rstn - asynchronous active-low reset
//               bus  - cpu_seq_ctrl_if.slave (controls in, strobes/status out)
// Parameters  : RUN_DIV - idle cycles between instructions in run mode (>=1)
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_seq_ctrl #(
    parameter int unsigned RUN_DIV = 4
) (
    input  wire logic      clk,
    input  wire logic      rstn,
    cpu_seq_ctrl_if.slave  bus
);

    // tick never exceeds RUN_DIV-1: reaching it either leaves IDLE or is
    // cleared by a breakpoint hit, so clog2(RUN_DIV) bits suffice.
    localparam int unsigned c_tick_w = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
    localparam logic [c_tick_w-1:0] c_tick_last = c_tick_w'(RUN_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [c_tick_w-1:0] r_tick;
    logic                r_step_q;
    logic                r_step_armed;
    logic                r_halted;
    logic [31:0]         r_instr_cnt;

    logic w_bp_hit;
    logic w_step_rise;
    logic w_run_go;
    logic w_step_go;
    logic w_ir_we;
    logic w_dm_en;
    logic w_rf_we;
    logic w_pc_we;

    assign w_bp_hit    = bus.bp_en_i & (bus.pc_i == bus.bp_addr_i);
    // After reset step_i must be seen low once before an edge can count, so a
    // button held through reset does not launch an instruction.
    assign w_step_rise = bus.step_i & ~r_step_q & r_step_armed;
    assign w_run_go    = bus.run_i & (r_tick == c_tick_last) & ~w_bp_hit;
    // In run mode a step is only meaningful to release a breakpoint halt.
    assign w_step_go   = w_step_rise & (~bus.run_i | r_halted);

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and strobes; strobes depend on r_state only.
    always_comb begin
        w_next  = S_IDLE;
        w_ir_we = 1'b0;
        w_dm_en = 1'b0;
        w_rf_we = 1'b0;
        w_pc_we = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_run_go || w_step_go) begin
                    w_next = S_FETCH;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_FETCH: begin
                w_next  = S_DECODE;
                w_ir_we = 1'b1;
            end
            S_DECODE: begin
                w_next = S_EXEC;
            end
            S_EXEC: begin
                w_next = bus.mem_op_i ? S_MEM : S_WB;
            end
            S_MEM: begin
                w_next  = S_WB;
                w_dm_en = 1'b1;
            end
            S_WB: begin
                w_next  = S_IDLE;
                w_rf_we = 1'b1;
                w_pc_we = 1'b1;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Step edge detect, run divider, halt flag, retired count
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_tick       <= '0;
            r_step_q     <= 1'b0;
            r_step_armed <= 1'b0;
            r_halted     <= 1'b0;
            r_instr_cnt  <= '0;
        end else begin
            r_step_q <= bus.step_i;
            if (!bus.step_i) begin
                r_step_armed <= 1'b1;
            end

            // Count only qualifying idle cycles; a breakpoint PC restarts the
            // count so run resumes RUN_DIV cycles after the PC moves on.
            if ((r_state == S_IDLE) && (w_next == S_IDLE) && bus.run_i && !w_bp_hit) begin
                r_tick <= r_tick + 1'b1;
            end else begin
                r_tick <= '0;
            end

            if (!bus.run_i || ((r_state == S_IDLE) && (w_next == S_FETCH))) begin
                r_halted <= 1'b0;
            end else if ((r_state == S_IDLE) && w_bp_hit) begin
                r_halted <= 1'b1;
            end

            if (r_state == S_WB) begin
                r_instr_cnt <= r_instr_cnt + 32'd1;
            end
        end
    end

    assign bus.ir_we_o     = w_ir_we;
    assign bus.dm_en_o     = w_dm_en;
    assign bus.rf_we_en_o  = w_rf_we;
    assign bus.pc_we_o     = w_pc_we;
    assign bus.phase_o     = r_state;
    assign bus.busy_o      = (r_state != S_IDLE);
    assign bus.halted_o    = r_halted;
    assign bus.instr_cnt_o = r_instr_cnt;

endmodule
`default_nettype wire

// File: tb/tb_cpu_seq_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_cpu_seq_ctrl
// Description : Self-checking bench for cpu_seq_ctrl: directed scenarios plus
//               randomized control traffic compared to a phase-queue model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_seq_ctrl;
    localparam int unsigned RUN_DIV = 4;

    logic clk  = 1'b0;
    logic rstn = 1'b0;

    cpu_seq_ctrl_if bus ();

    cpu_seq_ctrl #(.RUN_DIV(RUN_DIV)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: an instruction is a queue of phases still to visit;
    // an empty queue means idle. m_wait counts idle run-mode cycles spent at
    // a non-breakpoint PC.
    int          mq[$];
    int          m_wait;
    bit          m_halted;
    logic [31:0] m_cnt;
    bit          m_prev;
    bit          m_armed;

    function automatic int m_phase();
        return (mq.size() != 0) ? mq[0] : 0;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_wait   = 0;
        m_halted = 0;
        m_cnt    = 32'd0;
        m_prev   = 0;
        m_armed  = 0;
    endtask

    task automatic model_step();
        bit rise, bp, go;
        int p;
        rise    = bus.step_i && !m_prev && m_armed;
        m_prev  = bus.step_i;
        if (!bus.step_i) m_armed = 1;
        if (mq.size() != 0) begin
            p = mq.pop_front();
            if (p == 3) begin
                if (bus.mem_op_i) mq.push_back(4);
                mq.push_back(5);
            end
            if (p == 5) m_cnt = m_cnt + 32'd1;
            if (!bus.run_i) m_halted = 0;
        end else begin
            bp = bus.bp_en_i && (bus.pc_i == bus.bp_addr_i);
            go = (bus.run_i && (m_wait == RUN_DIV - 1) && !bp) ||
                 (rise && (!bus.run_i || m_halted));
            if (go) begin
                mq       = '{1, 2, 3};
                m_wait   = 0;
                m_halted = 0;
            end else begin
                m_wait = (bus.run_i && !bp) ? m_wait + 1 : 0;
                if (!bus.run_i)  m_halted = 0;
                else if (bp)     m_halted = 1;
            end
        end
    endtask

    // One clock: model advances on the same edge as the DUT, returns at the
    // following falling edge where outputs are sampled.
    task automatic cycle();
        @(posedge clk);
        if (rstn) model_step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rstn          = 1'b0;
        bus.run_i     = 1'b0;
        bus.step_i    = 1'b0;
        bus.bp_en_i   = 1'b0;
        bus.bp_addr_i = 32'h0;
        bus.pc_i      = 32'h0;
        bus.mem_op_i  = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        rstn = 1'b0;
        #1;
        n_cmp++; if (bus.phase_o !== 3'd0) begin n_bad++; $display("FAIL reset_phase got=%0d exp=0", bus.phase_o); end
        n_cmp++; if ({bus.ir_we_o, bus.dm_en_o, bus.rf_we_en_o, bus.pc_we_o} !== 4'b0) begin n_bad++; $display("FAIL reset_strobes got=%b exp=0000", {bus.ir_we_o, bus.dm_en_o, bus.rf_we_en_o, bus.pc_we_o}); end
        n_cmp++; if ({bus.busy_o, bus.halted_o} !== 2'b00) begin n_bad++; $display("FAIL reset_status got=%b exp=00", {bus.busy_o, bus.halted_o}); end
        n_cmp++; if (bus.instr_cnt_o !== 32'd0) begin n_bad++; $display("FAIL reset_cnt got=%0d exp=0", bus.instr_cnt_o); end
        @(negedge clk);
        rstn = 1'b1;
        // step_i high across reset release must not count as an edge
        bus.step_i = 1'b1;
        repeat (4) cycle();
        n_cmp++; if (bus.busy_o !== 1'b0) begin n_bad++; $display("FAIL reset_step_held got busy=%b exp=0", bus.busy_o); end
        bus.step_i = 1'b0;
    endtask

    task automatic test_step_mode();
        int exp_ph[5] = '{1, 2, 3, 5, 0};
        int pcw = 0;
        do_reset();
        repeat (2) cycle();
        bus.step_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle();
            bus.step_i = 1'b0;
            if (bus.pc_we_o === 1'b1) pcw++;
            n_cmp++; if (bus.phase_o !== 3'(exp_ph[i])) begin n_bad++; $display("FAIL step_phase[%0d] got=%0d exp=%0d", i, bus.phase_o, exp_ph[i]); end
        end
        n_cmp++; if (pcw != 1) begin n_bad++; $display("FAIL step_pc_we_pulses got=%0d exp=1", pcw); end
        n_cmp++; if (bus.instr_cnt_o !== 32'd1) begin n_bad++; $display("FAIL step_cnt got=%0d exp=1", bus.instr_cnt_o); end
    endtask

    task automatic test_load_path();
        int exp_ph[6] = '{1, 2, 3, 4, 5, 0};
        int dm_at = -1;
        int rf_at = -1;
        do_reset();
        bus.mem_op_i = 1'b1;
        repeat (2) cycle();
        bus.step_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cycle();
            bus.step_i = 1'b0;
            if (bus.dm_en_o === 1'b1)    dm_at = (dm_at < 0) ? i : 99;
            if (bus.rf_we_en_o === 1'b1) rf_at = (rf_at < 0) ? i : 99;
            n_cmp++; if (bus.phase_o !== 3'(exp_ph[i])) begin n_bad++; $display("FAIL load_phase[%0d] got=%0d exp=%0d", i, bus.phase_o, exp_ph[i]); end
        end
        n_cmp++; if (dm_at != 3 || rf_at != 4) begin n_bad++; $display("FAIL load_dm_rf_order got dm=%0d rf=%0d exp dm=3 rf=4", dm_at, rf_at); end
        bus.mem_op_i = 1'b0;
    endtask

    task automatic test_run_mode();
        int first = -1;
        int fetches = 1;
        int bad_gap = 0;
        do_reset();
        bus.run_i = 1'b1;
        for (int k = 1; k <= 20 && first < 0; k++) begin
            cycle();
            if (bus.phase_o === 3'd1) first = k;
        end
        n_cmp++; if (first != int'(RUN_DIV)) begin n_bad++; $display("FAIL run_first_fetch got=%0d exp=%0d", first, RUN_DIV); end
        for (int r = 1; r <= 80; r++) begin
            cycle();
            if (bus.phase_o === 3'd1) begin
                if (r < 80) fetches++;
                if (r % (RUN_DIV + 4) != 0) bad_gap++;
            end
        end
        n_cmp++; if (fetches != 10) begin n_bad++; $display("FAIL run_fetch_count got=%0d exp=10", fetches); end
        n_cmp++; if (bad_gap != 0) begin n_bad++; $display("FAIL run_fetch_spacing got=%0d off-period fetches exp=0", bad_gap); end
        n_cmp++; if (bus.instr_cnt_o !== 32'd10) begin n_bad++; $display("FAIL run_cnt got=%0d exp=10", bus.instr_cnt_o); end
        bus.run_i = 1'b0;
    endtask

    task automatic test_breakpoint();
        int busy_seen = 0;
        int exp_ph[4] = '{1, 2, 3, 5};
        do_reset();
        bus.run_i     = 1'b1;
        bus.bp_en_i   = 1'b1;
        bus.bp_addr_i = 32'h10;
        bus.pc_i      = 32'h10;
        repeat (10) begin
            cycle();
            if (bus.busy_o !== 1'b0) busy_seen++;
        end
        n_cmp++; if (busy_seen != 0) begin n_bad++; $display("FAIL bp_stays_idle got busy cycles=%0d exp=0", busy_seen); end
        n_cmp++; if (bus.halted_o !== 1'b1) begin n_bad++; $display("FAIL bp_halted got=%b exp=1", bus.halted_o); end
        bus.step_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            bus.step_i = 1'b0;
            n_cmp++; if ({bus.phase_o, bus.halted_o} !== {3'(exp_ph[i]), 1'b0}) begin n_bad++; $display("FAIL bp_step[%0d] got phase=%0d halted=%b exp phase=%0d halted=0", i, bus.phase_o, bus.halted_o, exp_ph[i]); end
        end
        repeat (2) cycle();
        n_cmp++; if ({bus.busy_o, bus.halted_o} !== 2'b01) begin n_bad++; $display("FAIL bp_rehalt got busy=%b halted=%b exp busy=0 halted=1", bus.busy_o, bus.halted_o); end
        n_cmp++; if (bus.instr_cnt_o !== 32'd1) begin n_bad++; $display("FAIL bp_cnt got=%0d exp=1", bus.instr_cnt_o); end
    endtask

    task automatic test_step_held();
        int fetches = 0;
        do_reset();
        repeat (2) cycle();
        bus.step_i = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (bus.phase_o === 3'd1) fetches++;
            if (i == 0) bus.step_i = 1'b0;
            if (i == 1) bus.step_i = 1'b1;   // second edge lands while busy
        end
        n_cmp++; if (fetches != 1) begin n_bad++; $display("FAIL held_fetches got=%0d exp=1", fetches); end
        n_cmp++; if (bus.instr_cnt_o !== 32'd1) begin n_bad++; $display("FAIL held_cnt got=%0d exp=1", bus.instr_cnt_o); end
        bus.step_i = 1'b0;
    endtask

    task automatic test_reset_mid_mem();
        bit found = 0;
        do_reset();
        bus.mem_op_i = 1'b1;
        repeat (2) cycle();
        repeat (5) begin
            bus.step_i = 1'b1;
            cycle();
            bus.step_i = 1'b0;
            repeat (7) cycle();
        end
        n_cmp++; if (bus.instr_cnt_o !== 32'd5) begin n_bad++; $display("FAIL midmem_precnt got=%0d exp=5", bus.instr_cnt_o); end
        bus.step_i = 1'b1;
        cycle();
        bus.step_i = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            if (bus.phase_o === 3'd4) found = 1;
            else cycle();
        end
        n_cmp++; if (!found) begin n_bad++; $display("FAIL midmem_reach_mem got=timeout exp=phase 4"); end
        rstn = 1'b0;
        #1;
        model_reset();
        n_cmp++; if ({bus.phase_o, bus.busy_o} !== 4'd0) begin n_bad++; $display("FAIL midmem_phase got phase=%0d busy=%b exp 0/0", bus.phase_o, bus.busy_o); end
        n_cmp++; if ({bus.ir_we_o, bus.dm_en_o, bus.rf_we_en_o, bus.pc_we_o} !== 4'b0) begin n_bad++; $display("FAIL midmem_strobes got=%b exp=0000", {bus.ir_we_o, bus.dm_en_o, bus.rf_we_en_o, bus.pc_we_o}); end
        n_cmp++; if (bus.instr_cnt_o !== 32'd0) begin n_bad++; $display("FAIL midmem_cnt got=%0d exp=0", bus.instr_cnt_o); end
        @(negedge clk);
        rstn = 1'b1;
        bus.mem_op_i = 1'b0;
    endtask

    task automatic test_random();
        int prints = 0;
        int ph;
        logic [3:0] exp_stb;
        do_reset();
        bus.bp_addr_i = 32'h10;
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(0, 39) == 0) bus.run_i   = ~bus.run_i;
            if ($urandom_range(0, 9) == 0)  bus.bp_en_i = ~bus.bp_en_i;
            bus.step_i   = ($urandom_range(0, 3) == 0);
            bus.mem_op_i = $urandom_range(0, 1) == 1;
            bus.pc_i     = ($urandom_range(0, 2) == 0) ? 32'h10 : 32'($urandom_range(0, 255)) & 32'hFC;
            cycle();
            ph      = m_phase();
            exp_stb = {ph == 1, ph == 4, ph == 5, ph == 5};
            n_cmp++; if (bus.phase_o !== 3'(ph)) begin n_bad++; if (prints++ < 20) $display("FAIL rnd_phase c=%0d got=%0d exp=%0d", c, bus.phase_o, ph); end
            n_cmp++; if ({bus.ir_we_o, bus.dm_en_o, bus.rf_we_en_o, bus.pc_we_o} !== exp_stb) begin n_bad++; if (prints++ < 20) $display("FAIL rnd_strobes c=%0d got=%b exp=%b", c, {bus.ir_we_o, bus.dm_en_o, bus.rf_we_en_o, bus.pc_we_o}, exp_stb); end
            n_cmp++; if (bus.busy_o !== (ph != 0)) begin n_bad++; if (prints++ < 20) $display("FAIL rnd_busy c=%0d got=%b exp=%b", c, bus.busy_o, ph != 0); end
            n_cmp++; if (bus.halted_o !== m_halted) begin n_bad++; if (prints++ < 20) $display("FAIL rnd_halted c=%0d got=%b exp=%b", c, bus.halted_o, m_halted); end
            n_cmp++; if (bus.instr_cnt_o !== m_cnt) begin n_bad++; if (prints++ < 20) $display("FAIL rnd_cnt c=%0d got=%0d exp=%0d", c, bus.instr_cnt_o, m_cnt); end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        do_reset();
        test_reset();
        test_step_mode();
        test_load_path();
        test_run_mode();
        test_breakpoint();
        test_step_held();
        test_reset_mid_mem();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cpu_seq_ctrl.md
CPU_SEQ_CTRL -- requirements
Module: cpu_seq_ctrl

Interface
REQ-001 SHALL have parameter RUN_DIV, default 4, clk cycles spent in IDLE between instructions in run mode (legal >= 1).
REQ-002 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port run_i  input  1  synchronous level; 1 = free-run, 0 = single-step mode.
REQ-005 SHALL have port step_i  input  1  synchronous level; a rising edge requests one instruction.
REQ-006 SHALL have port bp_en_i  input  1  breakpoint enable.
REQ-007 SHALL have port bp_addr_i  input  32  breakpoint PC.
REQ-008 SHALL have port pc_i  input  32  current datapath PC.
REQ-009 SHALL have port mem_op_i  input  1  decoded instruction is load/store; sampled in EXEC.
REQ-010 SHALL have port ir_we_o  output  1  instruction-register load strobe.
REQ-011 SHALL have port dm_en_o  output  1  data-memory access enable.
REQ-012 SHALL have port rf_we_en_o  output  1  register-file write qualifier.
REQ-013 SHALL have port pc_we_o  output  1  PC update strobe.
REQ-014 SHALL have port phase_o  output  3  current state encoding.
REQ-015 SHALL have port busy_o  output  1  1 in any state other than IDLE.
REQ-016 SHALL have port halted_o  output  1  breakpoint stop indicator.
REQ-017 SHALL have port instr_cnt_o  output  32  retired-instruction count.

Function
REQ-018 SHALL implement states IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5; encodings 6-7 SHALL go to IDLE next cycle with all strobes 0.
REQ-019 SHALL hold every non-IDLE state exactly one cycle: FETCH->DECODE->EXEC; EXEC->MEM if mem_op_i=1, else EXEC->WB; MEM->WB; WB->IDLE.
REQ-020 SHALL decode strobes from the state register only: ir_we_o=FETCH, dm_en_o=MEM, rf_we_en_o=WB, pc_we_o=WB; no input-to-output combinational path.
REQ-021 SHALL register step_i every cycle; step_rise = step_i & ~step_q.
REQ-022 SHALL increment a tick counter in IDLE while run_i=1, clear it on leaving IDLE, and clear it while run_i=0.
REQ-023 SHALL define bp_hit = bp_en_i & (pc_i == bp_addr_i), evaluated in IDLE.
REQ-024 SHALL leave IDLE for FETCH when (run_i & tick==RUN_DIV-1 & ~bp_hit) or (step_rise & (~run_i | halted_o)).
REQ-025 SHALL set halted_o in IDLE when run_i & bp_hit, and clear it on the cycle FETCH is entered or when run_i=0.
REQ-026 SHALL allow a step_rise while halted to execute exactly one instruction; run then resumes only after RUN_DIV idle cycles at a non-breakpoint PC.
REQ-027 SHALL discard step_rise while busy_o=1 (no queuing), and discard step_rise when run_i=1 and halted_o=0.
REQ-028 SHALL increment instr_cnt_o by 1 on each WB cycle, wrapping 0xFFFFFFFF->0.
REQ-029 SHALL give instruction latency of 4 cycles FETCH-to-WB without MEM, 5 with MEM; run-mode period is RUN_DIV+4 or RUN_DIV+5 cycles.
REQ-030 SHALL let a run_i change mid-instruction complete the instruction; the mode is evaluated only in IDLE.

Reset
REQ-031 SHALL, on rstn=0 at any time including mid-instruction, asynchronously force state=IDLE, tick=0, step_q=0, halted_o=0, instr_cnt_o=0, all strobes 0, phase_o=0, busy_o=0.
REQ-032 SHALL, after rstn deasserts, not treat step_i already high as a rising edge until it has been sampled low once.

Verification
REQ-033 Step mode: run_i=0, pulse step_i, mem_op_i=0 -> phase_o 1,2,3,5,0 on consecutive cycles; single pc_we_o pulse; instr_cnt_o=1.
REQ-034 Load path: step with mem_op_i=1 -> phase 1,2,3,4,5,0; dm_en_o high exactly one cycle before rf_we_en_o.
REQ-035 Run mode: run_i=1, RUN_DIV=4, mem_op_i=0 -> FETCH every 8 cycles; instr_cnt_o=10 after 80 cycles from first FETCH.
REQ-036 Breakpoint: run_i=1, bp_en_i=1, bp_addr_i=pc_i=0x10 -> stays IDLE, halted_o=1; step pulse -> one instruction, halted_o=0 during it.
REQ-037 Step held high 20 cycles, plus a second edge during busy -> exactly one instruction executed.
REQ-038 rstn low during MEM with instr_cnt_o=5 -> immediately phase_o=0, strobes 0, instr_cnt_o=0.
